// File: rtl/branch_outcome_driver_pkg.sv
// Shared defaults, direction constants and the training-register payload
// for the branch outcome driver.
package branch_outcome_driver_pkg;

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // One-cycle training beat sent back to the predictor after a resolve.
    typedef struct packed {
        logic result;
        logic taken;
        logic miss;
    } train_t;

endpackage

// File: rtl/branch_outcome_driver_fifo.sv
// In-order store of returned predictions, DEPTH x 1 bit.
// Pointers carry one extra wrap bit to tell full from empty.
module branch_outcome_driver_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned AW    = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset; empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/branch_outcome_driver.sv
// Requester-side partner of the 2-bit branch predictor: issues requests,
// queues predictions in order, pairs them with resolutions and trains.
module branch_outcome_driver
    import branch_outcome_driver_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       br_valid,
    output logic                       br_ready,
    output logic                       pred_request,
    input  logic                       pred_in,
    output logic                       guess_valid,
    output logic                       guess,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       pred_result,
    output logic                       pred_taken,
    output logic                       mispredict,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           miss_count,
    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int unsigned OUT_W = $clog2(DEPTH) + 1;

    logic   accept;
    logic   pop;
    logic   head;
    logic   empty;
    logic   req_s2;
    logic   miss;
    train_t train_q;

    assign br_ready  = (outstanding < OUT_W'(DEPTH));
    assign res_ready = !empty;
    assign accept    = br_valid && br_ready;
    assign pop       = res_valid && !empty;
    assign miss      = pop && (head != res_taken);

    assign pred_result = train_q.result;
    assign pred_taken  = train_q.taken;
    assign mispredict  = train_q.miss;

    // Prediction arrives two edges after accept, aligned with req_s2.
    branch_outcome_driver_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_s2),
        .din   (pred_in),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_request <= 1'b0;
            req_s2       <= 1'b0;
            guess_valid  <= 1'b0;
            guess        <= 1'b0;
            train_q      <= '0;
            branch_count <= '0;
            miss_count   <= '0;
            outstanding  <= '0;
        end else begin
            pred_request <= accept;
            req_s2       <= pred_request;
            guess_valid  <= req_s2;
            if (req_s2) guess <= pred_in;

            train_q.result <= pop;
            train_q.taken  <= pop ? res_taken : NOT_TAKEN;
            train_q.miss   <= miss;

            // Saturating event counters.
            if (pop && (branch_count != '1)) branch_count <= branch_count + CNT_W'(1);
            if (miss && (miss_count != '1))  miss_count   <= miss_count + CNT_W'(1);

            case ({accept, pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_outcome_driver.sv
// Bench: driver + behavioural 2-bit predictor, checked every cycle against a
// queue-based system model; a CNT_W=2 copy checks counter saturation.
module tb_branch_outcome_driver;
    import branch_outcome_driver_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int CAP_A = 65535;
    localparam int CAP_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic br_valid = 1'b0;
    logic res_valid = 1'b0;
    logic res_taken = 1'b0;
    logic pred_in;

    logic        a_br_ready, a_pred_request, a_guess_valid, a_guess, a_res_ready;
    logic        a_pred_result, a_pred_taken, a_mispredict;
    logic [15:0] a_branch_count, a_miss_count;
    logic [2:0]  a_outstanding;

    logic        b_br_ready, b_pred_request, b_guess_valid, b_guess, b_res_ready;
    logic        b_pred_result, b_pred_taken, b_mispredict;
    logic [1:0]  b_branch_count, b_miss_count;
    logic [2:0]  b_outstanding;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_outcome_driver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(a_br_ready),
        .pred_request(a_pred_request), .pred_in(pred_in), .guess_valid(a_guess_valid),
        .guess(a_guess), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(a_res_ready), .pred_result(a_pred_result), .pred_taken(a_pred_taken),
        .mispredict(a_mispredict), .branch_count(a_branch_count),
        .miss_count(a_miss_count), .outstanding(a_outstanding)
    );

    branch_outcome_driver #(.DEPTH(DEPTH), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(b_br_ready),
        .pred_request(b_pred_request), .pred_in(pred_in), .guess_valid(b_guess_valid),
        .guess(b_guess), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(b_res_ready), .pred_result(b_pred_result), .pred_taken(b_pred_taken),
        .mispredict(b_mispredict), .branch_count(b_branch_count),
        .miss_count(b_miss_count), .outstanding(b_outstanding)
    );

    // Behavioural 2-bit saturating predictor, powers up strongly taken.
    logic [1:0] p_state = 2'b11;
    logic       p_pred  = 1'b0;
    assign pred_in = p_pred;

    always @(posedge clk) begin
        if (a_pred_request === 1'b1) p_pred <= p_state[1];
        if (a_pred_result === 1'b1) begin
            if (a_pred_taken === TAKEN) p_state <= (p_state == 2'd3) ? 2'd3 : p_state + 2'd1;
            else                        p_state <= (p_state == 2'd0) ? 2'd0 : p_state - 2'd1;
        end
    end

    // System model: predictor counter, request age slots, prediction queue.
    int m_state = 3;
    bit m_ppred = 1'b0;
    bit m_req1 = 1'b0, m_req2 = 1'b0;
    bit q[$];
    int m_out = 0;
    bit m_pres = 0, m_ptaken = 0, m_mis = 0, m_gv = 0, m_guess = 0;
    int m_bc = 0, m_mc = 0;

    function automatic int sat(int v, int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit bv, input bit rv, input bit rt, input bit run);
        bit acc, push, val, pop, head;
        acc  = bv && (m_out < DEPTH);
        push = m_req2;
        val  = m_ppred;
        pop  = rv && (q.size() > 0);
        head = pop ? q[0] : 1'b0;
        if (m_req1) m_ppred = (m_state >= 2);
        if (m_pres) m_state = m_ptaken ? ((m_state < 3) ? m_state + 1 : 3)
                                       : ((m_state > 0) ? m_state - 1 : 0);
        if (!run) begin
            q.delete();
            {m_req1, m_req2, m_pres, m_ptaken, m_mis, m_gv, m_guess} = '0;
            m_out = 0; m_bc = 0; m_mc = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(val);
            m_req2   = m_req1;
            m_req1   = acc;
            m_gv     = push;
            if (push) m_guess = val;
            m_pres   = pop;
            m_ptaken = pop ? rt : 1'b0;
            m_mis    = pop && (head != rt);
            if (pop) m_bc++;
            if (pop && head != rt) m_mc++;
            m_out = m_out + int'(acc) - int'(pop);
        end
    endtask

    task automatic check_all();
        chk("a_pred_request", 32'(a_pred_request), 32'(m_req1));
        chk("a_guess_valid",  32'(a_guess_valid),  32'(m_gv));
        chk("a_guess",        32'(a_guess),        32'(m_guess));
        chk("a_pred_result",  32'(a_pred_result),  32'(m_pres));
        chk("a_pred_taken",   32'(a_pred_taken),   32'(m_ptaken));
        chk("a_mispredict",   32'(a_mispredict),   32'(m_mis));
        chk("a_branch_count", 32'(a_branch_count), 32'(sat(m_bc, CAP_A)));
        chk("a_miss_count",   32'(a_miss_count),   32'(sat(m_mc, CAP_A)));
        chk("a_outstanding",  32'(a_outstanding),  32'(m_out));
        chk("b_pred_request", 32'(b_pred_request), 32'(m_req1));
        chk("b_guess_valid",  32'(b_guess_valid),  32'(m_gv));
        chk("b_guess",        32'(b_guess),        32'(m_guess));
        chk("b_pred_result",  32'(b_pred_result),  32'(m_pres));
        chk("b_pred_taken",   32'(b_pred_taken),   32'(m_ptaken));
        chk("b_mispredict",   32'(b_mispredict),   32'(m_mis));
        chk("b_branch_count", 32'(b_branch_count), 32'(sat(m_bc, CAP_B)));
        chk("b_miss_count",   32'(b_miss_count),   32'(sat(m_mc, CAP_B)));
        chk("b_outstanding",  32'(b_outstanding),  32'(m_out));
    endtask

    task automatic step(input bit bv, input bit rv, input bit rt);
        br_valid  = bv;
        res_valid = rv;
        res_taken = rt;
        chk("a_br_ready",  32'(a_br_ready),  32'(m_out < DEPTH));
        chk("a_res_ready", 32'(a_res_ready), 32'(q.size() > 0));
        chk("b_br_ready",  32'(b_br_ready),  32'(m_out < DEPTH));
        chk("b_res_ready", 32'(b_res_ready), 32'(q.size() > 0));
        model_edge(bv, rv, rt, 1'b1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; br_valid = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_edge(1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset(2);
        chk("t1_br_ready",    32'(a_br_ready),    32'd1);
        chk("t1_res_ready",   32'(a_res_ready),   32'd0);
        chk("t1_outstanding", 32'(a_outstanding), 32'd0);

        // Single taken branch
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t2_guess", 32'(a_guess), 32'd1);
        step(0, 1, 1);
        chk("t2_pred_taken",   32'(a_pred_taken),   32'd1);
        chk("t2_mispredict",   32'(a_mispredict),   32'd0);
        chk("t2_branch_count", 32'(a_branch_count), 32'd1);
        step(0, 0, 0);

        // Four not-taken branches, one at a time
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
            chk("t3_guess", 32'(a_guess), (i < 2) ? 32'd1 : 32'd0);
            step(0, 1, 0);
            chk("t3_mispredict", 32'(a_mispredict), (i < 2) ? 32'd1 : 32'd0);
            step(0, 0, 0);
        end
        chk("t3_miss_count", 32'(a_miss_count), 32'd2);

        // Fill to DEPTH, then simultaneous resolve + accept
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("t4_outstanding", 32'(a_outstanding), 32'd4);
        chk("t4_br_ready",    32'(a_br_ready),    32'd0);
        step(0, 1, 1);
        step(1, 1, 0);
        chk("t4_same_edge", 32'(a_outstanding), 32'd3);
        for (int i = 0; i < 8; i++) step(0, 1, 1);

        // Resolve while the only branch is still in the request pipeline
        step(1, 0, 0);
        step(0, 1, 0);
        chk("t5_no_pop", 32'(a_pred_result), 32'd0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("t5_pop", 32'(a_pred_result), 32'd1);
        step(0, 0, 0);

        // Mid-operation reset with three outstanding
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        do_reset(1);
        chk("t6_outstanding", 32'(a_outstanding), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        // Five misses: small counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
            step(0, 1, !q[0]);
            step(0, 0, 0);
        end
        chk("t6_miss_sat",  32'(b_miss_count), 32'd3);
        chk("t6_miss_full", 32'(a_miss_count), 32'd5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) do_reset(1);
            else step(1'($urandom), 1'($urandom_range(2) != 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
